// File: rtl/servo_pkg.sv
// Shared definitions for the servo array controller: address/control bit positions and
// receive FSM states.
package servo_pkg;

  localparam int unsigned ADDR_CTRL_BIT = 7;

  localparam int unsigned CTL_EN      = 0;
  localparam int unsigned CTL_INV     = 1;
  localparam int unsigned CTL_RATE_HI = 7;
  localparam int unsigned CTL_RATE_LO = 4;

  typedef enum logic [0:0] {
    S_ADDR = 1'b0,
    S_DATA = 1'b1
  } rx_state_e;

  // Data bytes needed to carry one position value.
  function automatic int unsigned data_bytes(int unsigned pos_w);
    return (pos_w + 7) / 8;
  endfunction

endpackage

// File: rtl/servo_if.sv
// Byte stream from the SPI slave into the servo controller.
interface servo_if;
  logic       frame;
  logic       byte_valid;
  logic [7:0] data;

  modport master (output frame, byte_valid, data);
  modport slave  (input  frame, byte_valid, data);
endinterface

// File: rtl/servo_channel.sv
// One servo channel: shadow/active position, control register, optional slew ramp and PWM
// comparator. The slew ramp is built only when SERVO_RAMP_EN is defined.
module servo_channel
  import servo_pkg::*;
#(
  parameter int unsigned POS_W     = 8,
  parameter int unsigned CNT_W     = 15,
  parameter int unsigned MIN_TICKS = 1000,
  parameter int unsigned LSB_TICKS = 4
) (
  input  logic             clk_i,
  input  logic             rst,
  input  logic             pos_we_i,
  input  logic             ctl_we_i,
  input  logic [POS_W-1:0] pos_wdata_i,
  input  logic [7:0]       ctl_wdata_i,
  input  logic             boundary_i,
  input  logic [CNT_W-1:0] frame_cnt_i,
  output logic             pwm_o
);

  logic [POS_W-1:0] shadow_q;
  logic [POS_W-1:0] active_q;
  logic [POS_W-1:0] active_d;
  logic [7:0]       ctl_q;
  logic             pwm_q;
  logic [31:0]      width;
  logic             unused_ctl;

`ifdef SERVO_RAMP_EN
  logic [POS_W+3:0] step;
  logic [POS_W-1:0] dist;

  always_comb begin
    // rate << (POS_W-4), written so that narrow POS_W never needs a negative shift
    step     = ({{POS_W{1'b0}}, ctl_q[CTL_RATE_HI:CTL_RATE_LO]} << POS_W) >> 4;
    dist     = (shadow_q >= active_q) ? (shadow_q - active_q) : (active_q - shadow_q);
    active_d = shadow_q;
    if (step != '0 && {4'b0000, dist} > step) begin
      if (shadow_q > active_q) begin
        active_d = active_q + step[POS_W-1:0];
      end else begin
        active_d = active_q - step[POS_W-1:0];
      end
    end
  end

  assign unused_ctl = ^ctl_q[3:2];
`else
  assign active_d   = shadow_q;
  assign unused_ctl = ^{ctl_q[7:4], ctl_q[3:2]};
`endif

  assign width = 32'(MIN_TICKS) + 32'(active_q) * 32'(LSB_TICKS);

  always_ff @(posedge clk_i) begin
    if (rst) begin
      shadow_q <= '0;
      active_q <= '0;
      ctl_q    <= '0;
      pwm_q    <= 1'b0;
    end else begin
      if (pos_we_i) shadow_q <= pos_wdata_i;
      if (ctl_we_i) ctl_q <= ctl_wdata_i;
      // A shadow write landing on the boundary cycle is picked up one frame later.
      if (boundary_i) active_q <= active_d;
      pwm_q <= ctl_q[CTL_EN] & ((32'(frame_cnt_i) < width) ^ ctl_q[CTL_INV]);
    end
  end

  assign pwm_o = pwm_q;

endmodule

// File: rtl/servo_array_ctrl.sv
// N-channel servo PWM controller fed by the SPI slave byte stream. Holds the receive FSM,
// prescaler, frame counter and address decode. Optional slew ramp: SERVO_RAMP_EN.
module servo_array_ctrl
  import servo_pkg::*;
#(
  parameter int unsigned CHANNELS    = 8,
  parameter int unsigned POS_W       = 8,
  parameter int unsigned PRESCALE    = 16,
  parameter int unsigned FRAME_TICKS = 20000,
  parameter int unsigned MIN_TICKS   = 1000,
  parameter int unsigned LSB_TICKS   = 4
) (
  input  logic                clk_i,
  input  logic                rst,
  servo_if.slave              spi,
  output logic [CHANNELS-1:0] pwm_o,
  output logic                frame_sync_o,
  output logic                err_o
);

  localparam int unsigned DBYTES = data_bytes(POS_W);
  localparam int unsigned ACC_W  = DBYTES * 8;
  localparam int unsigned PRE_W  = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int unsigned CNT_W  = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
  localparam int unsigned BCNT_W = (DBYTES > 1) ? $clog2(DBYTES) : 1;

  if (CHANNELS < 1 || CHANNELS > 128 || POS_W < 1 || POS_W > 16 || PRESCALE < 1 ||
      64'(MIN_TICKS) + ((64'd1 << POS_W) - 64'd1) * 64'(LSB_TICKS) >= 64'(FRAME_TICKS))
  begin : g_bad_cfg
    $error("servo_array_ctrl: parameters out of range or pulse can exceed the frame");
  end

  // Prescaler and frame counter
  logic [PRE_W-1:0] presc_q;
  logic [CNT_W-1:0] frame_cnt_q;
  logic             frame_sync_q;
  logic             tick;
  logic             boundary;

  assign tick     = (presc_q == PRE_W'(PRESCALE - 1));
  assign boundary = tick && (frame_cnt_q == CNT_W'(FRAME_TICKS - 1));

  always_ff @(posedge clk_i) begin
    if (rst) begin
      presc_q      <= '0;
      frame_cnt_q  <= '0;
      frame_sync_q <= 1'b0;
    end else begin
      presc_q <= tick ? '0 : presc_q + 1'b1;
      if (tick) begin
        frame_cnt_q <= (frame_cnt_q == CNT_W'(FRAME_TICKS - 1)) ? '0 : frame_cnt_q + 1'b1;
      end
      frame_sync_q <= boundary;
    end
  end

  // Receive FSM and decode
  rx_state_e         state_q;
  logic [7:0]        addr_q;
  logic [BCNT_W-1:0] bcnt_q;
  logic [ACC_W-1:0]  acc_q;
  logic              err_q;

  logic              rx_byte;
  logic              is_ctl;
  logic              in_range;
  logic              last_byte;
  logic              commit;
  logic [6:0]        chan;
  logic [ACC_W+7:0]  cat;
  logic [POS_W-1:0]  pos_wdata;
  logic [CHANNELS-1:0] pos_we;
  logic [CHANNELS-1:0] ctl_we;
  logic              unused_cat;

  always_comb begin
    rx_byte   = spi.frame & spi.byte_valid;
    is_ctl    = addr_q[ADDR_CTRL_BIT];
    chan      = addr_q[6:0];
    in_range  = (32'(chan) < CHANNELS);
    last_byte = is_ctl || (bcnt_q == BCNT_W'(DBYTES - 1));
    commit    = rx_byte && (state_q == S_DATA) && last_byte;
    // Earlier bytes sit in acc_q; the current byte completes the value in place.
    cat       = {acc_q, spi.data};
  end

  assign pos_wdata  = cat[POS_W-1:0];
  assign unused_cat = ^cat[ACC_W+7:POS_W];

  always_comb begin
    pos_we = '0;
    ctl_we = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      pos_we[i] = commit && !is_ctl && (32'(chan) == i);
      ctl_we[i] = commit && is_ctl && (32'(chan) == i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst) begin
      state_q <= S_ADDR;
      addr_q  <= '0;
      bcnt_q  <= '0;
      acc_q   <= '0;
      err_q   <= 1'b0;
    end else if (!spi.frame) begin
      state_q <= S_ADDR;
      bcnt_q  <= '0;
    end else if (spi.byte_valid) begin
      unique case (state_q)
        S_ADDR: begin
          addr_q  <= spi.data;
          bcnt_q  <= '0;
          state_q <= S_DATA;
        end
        S_DATA: begin
          acc_q  <= cat[ACC_W-1:0];
          bcnt_q <= bcnt_q + 1'b1;
          if (last_byte) begin
            state_q <= S_ADDR;
            if (!in_range) err_q <= 1'b1;
          end
        end
        default: state_q <= S_ADDR;
      endcase
    end
  end

  assign frame_sync_o = frame_sync_q;
  assign err_o        = err_q;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    servo_channel #(
      .POS_W     (POS_W),
      .CNT_W     (CNT_W),
      .MIN_TICKS (MIN_TICKS),
      .LSB_TICKS (LSB_TICKS)
    ) u_chan (
      .clk_i       (clk_i),
      .rst         (rst),
      .pos_we_i    (pos_we[i]),
      .ctl_we_i    (ctl_we[i]),
      .pos_wdata_i (pos_wdata),
      .ctl_wdata_i (spi.data),
      .boundary_i  (boundary),
      .frame_cnt_i (frame_cnt_q),
      .pwm_o       (pwm_o[i])
    );
  end

endmodule
